// File: rtl/bloon_background_rom_arbiter.sv
// Shares the 640x480 background ROM between VGA scan-out and one game-logic lookup port.
// Video owns every active-display cycle; game lookups are issued only during blanking.
module bloon_background_rom_arbiter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int WAIT_W = 16
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [18:0]       rom_address,
    input  logic [4:0]        rom_q,
    output logic [4:0]        vid_index,
    output logic              vid_active,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    output logic              rsp_valid,
    output logic [4:0]        rsp_index,
    output logic              rsp_err,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VIDEO,
        OWN_GAME
    } owner_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t      state;
    owner_t      owner;
    owner_t      owner_d1;
    logic        blank_d1;
    logic [18:0] vid_addr;
    logic [18:0] req_addr_next;
    logic [18:0] req_addr_reg;

    // 640 = 512 + 128, so the stride reduces to two shifted adds.
    generate
        if (H_RES == 640) begin : g_shift_stride
            assign vid_addr      = {9'd0, DrawX} + {DrawY, 9'd0} + {2'd0, DrawY, 7'd0};
            assign req_addr_next = {9'd0, req_x} + {req_y, 9'd0} + {2'd0, req_y, 7'd0};
        end else begin : g_mul_stride
            assign vid_addr      = {9'd0, DrawX} + ({9'd0, DrawY} * 19'(H_RES));
            assign req_addr_next = {9'd0, req_x} + ({9'd0, req_y} * 19'(H_RES));
        end
    endgenerate

    // The address only moves when the owner select moves, so a waiting game request never glitches video.
    always_comb begin
        owner       = OWN_NONE;
        rom_address = '0;
        if (blank) begin
            owner       = OWN_VIDEO;
            rom_address = vid_addr;
        end else if (state == S_ISSUE) begin
            owner       = OWN_GAME;
            rom_address = req_addr_reg;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            owner_d1   <= OWN_NONE;
            blank_d1   <= 1'b0;
            vid_index  <= '0;
            vid_active <= 1'b0;
        end else begin
            owner_d1   <= owner;
            blank_d1   <= blank;
            vid_active <= blank_d1;
            vid_index  <= (owner_d1 == OWN_VIDEO) ? rom_q : 5'd0;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            req_ready    <= 1'b0;
            req_addr_reg <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_index    <= '0;
            wait_cnt     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready    <= 1'b0;
                        wait_cnt     <= '0;
                        req_addr_reg <= req_addr_next;
                        if (req_x >= H_LIM || req_y >= V_LIM) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!blank) begin
                        state <= S_WAIT;
                    end else if (wait_cnt != {WAIT_W{1'b1}}) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                // rom_q now holds the game read issued last cycle.
                S_WAIT: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_index <= rom_q;
                end
                S_ERR: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_index <= '0;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bloon_background_rom_arbiter.sv
// Directed plus randomized bench for bloon_background_rom_arbiter, checked against a
// transaction-level model of video latency and game request timing.
module tb_bloon_background_rom_arbiter;

    localparam int WW   = 3;
    localparam int WMAX = (1 << WW) - 1;
    localparam int NEVER = 1 << 30;

    logic          vga_clk = 1'b0;
    logic          reset = 1'b0;
    logic [9:0]    DrawX = '0;
    logic [9:0]    DrawY = '0;
    logic          blank = 1'b0;
    logic [18:0]   rom_address;
    logic [4:0]    rom_q;
    logic [4:0]    vid_index;
    logic          vid_active;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [9:0]    req_x = '0;
    logic [9:0]    req_y = '0;
    logic          rsp_valid;
    logic [4:0]    rsp_index;
    logic          rsp_err;
    logic [WW-1:0] wait_cnt;

    always #5 vga_clk = ~vga_clk;

    bloon_background_rom_arbiter #(
        .H_RES(640),
        .V_RES(480),
        .WAIT_W(WW)
    ) dut (
        .vga_clk(vga_clk),
        .reset(reset),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .blank(blank),
        .rom_address(rom_address),
        .rom_q(rom_q),
        .vid_index(vid_index),
        .vid_active(vid_active),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x(req_x),
        .req_y(req_y),
        .rsp_valid(rsp_valid),
        .rsp_index(rsp_index),
        .rsp_err(rsp_err),
        .wait_cnt(wait_cnt)
    );

    // ROM contents: plain addr[4:0], or a fold of all address bits so the Y term is visible too.
    logic rom_fold = 1'b0;
    function automatic logic [4:0] rom_fn(input logic [18:0] a, input logic fold);
        return fold ? (a[4:0] ^ a[9:5] ^ a[14:10] ^ {1'b0, a[18:15]}) : a[4:0];
    endfunction

    always_ff @(posedge vga_clk) rom_q <= rom_fn(rom_address, rom_fold);

    typedef struct {
        logic       act;
        logic [4:0] idx;
    } vexp_t;

    vexp_t      vq[$];
    int         checks = 0;
    int         errors = 0;
    int         n;
    int         ready_from;
    int         rsp_at;
    int         acc_cyc;
    int         iss_cyc;
    bit         pend;
    logic [18:0] pend_addr;
    logic [4:0]  rsp_idx_e;
    logic        rsp_err_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic int exp_wait(input int cyc);
        int w;
        if (acc_cyc < 0) return 0;
        w = ((cyc < iss_cyc) ? cyc : iss_cyc) - acc_cyc - 1;
        return (w > WMAX) ? WMAX : w;
    endfunction

    // One clock: check the combinational address, advance the model, then check registered outputs.
    task automatic cycle();
        int    va;
        int    exp_addr;
        vexp_t e;
        #1;
        va = int'(DrawX) + int'(DrawY) * 640;
        if (blank)     exp_addr = va;
        else if (pend) exp_addr = int'(pend_addr);
        else           exp_addr = 0;
        check("rom_address", rom_address, exp_addr);
        if (!blank && pend) begin
            pend       = 0;
            iss_cyc    = n;
            rsp_at     = n + 2;
            rsp_idx_e  = rom_fn(pend_addr, rom_fold);
            rsp_err_e  = 1'b0;
            ready_from = n + 3;
        end
        if (req_valid && n >= ready_from) begin
            acc_cyc = n;
            if (req_x >= 640 || req_y >= 480) begin
                iss_cyc    = n + 1;
                rsp_at     = n + 2;
                rsp_idx_e  = 5'd0;
                rsp_err_e  = 1'b1;
                ready_from = n + 3;
            end else begin
                pend       = 1;
                pend_addr  = 19'(int'(req_x) + int'(req_y) * 640);
                iss_cyc    = NEVER;
                ready_from = NEVER;
            end
        end
        e.act = blank;
        e.idx = blank ? rom_fn(19'(va), rom_fold) : 5'd0;
        vq.push_back(e);
        @(posedge vga_clk);
        #1;
        n++;
        e = vq.pop_front();
        check("vid_active", vid_active, e.act);
        check("vid_index", vid_index, e.idx);
        check("rsp_valid", rsp_valid, (n == rsp_at));
        if (n == rsp_at) begin
            check("rsp_index", rsp_index, rsp_idx_e);
            check("rsp_err", rsp_err, rsp_err_e);
        end
        check("req_ready", req_ready, (n >= ready_from));
        check("wait_cnt", wait_cnt, exp_wait(n));
    endtask

    task automatic step(input logic bl, input int dx, input int dy,
                        input logic rv, input int rx, input int ry);
        blank     = bl;
        DrawX     = 10'(dx);
        DrawY     = 10'(dy);
        req_valid = rv;
        req_x     = 10'(rx);
        req_y     = 10'(ry);
        cycle();
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        vexp_t z;
        reset     = 1'b1;
        req_valid = 1'b0;
        blank     = 1'b0;
        #1;
        check("rst_vid_index", vid_index, 0);
        check("rst_vid_active", vid_active, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_index", rsp_index, 0);
        check("rst_wait_cnt", wait_cnt, 0);
        check("rst_req_ready", req_ready, 0);
        repeat (2) @(posedge vga_clk);
        #1;
        reset      = 1'b0;
        n          = 0;
        ready_from = 1;
        rsp_at     = -1;
        acc_cyc    = -1;
        iss_cyc    = NEVER;
        pend       = 0;
        vq.delete();
        z.act = 1'b0;
        z.idx = 5'd0;
        vq.push_back(z);
        #1;
        check("ready_at_release", req_ready, 0);
    endtask

    initial begin
        logic bl;
        n = 0;
        #3;
        do_reset();

        // Video only: expect 0, 1, 31 two cycles later.
        step(1'b1, 0, 0, 1'b0, 0, 0);
        step(1'b1, 1, 0, 1'b0, 0, 0);
        step(1'b1, 639, 479, 1'b0, 0, 0);
        idle(3);

        // Request in blanking: address 1285, response index 5.
        step(1'b0, 0, 0, 1'b1, 5, 2);
        idle(5);

        // Request during active video: 7 waiting cycles reach the 3-bit ceiling exactly.
        step(1'b1, 20, 30, 1'b1, 10, 10);
        for (int i = 0; i < 7; i++) step(1'b1, 21 + i, 30, 1'b0, 0, 0);
        idle(5);

        // Longer wait must saturate.
        step(1'b1, 100, 200, 1'b1, 300, 400);
        for (int i = 0; i < 12; i++) step(1'b1, 101 + i, 200, 1'b0, 0, 0);
        idle(5);

        // Out of range on each axis, then the far in-range corner.
        step(1'b0, 0, 0, 1'b1, 640, 0);
        idle(4);
        step(1'b0, 0, 0, 1'b1, 0, 480);
        idle(4);
        step(1'b0, 0, 0, 1'b1, 639, 479);
        idle(5);

        // Held request with blank rising during WAIT: back-to-back accepts.
        for (int i = 0; i < 12; i++) step((i >= 2 && i < 6), 5 * i, 7, 1'b1, 33 + i, 44);
        idle(6);

        // Reset while the ROM access is in flight.
        step(1'b0, 0, 0, 1'b1, 50, 60);
        step(1'b0, 0, 0, 1'b0, 0, 0);
        do_reset();
        idle(5);

        // Randomized traffic with blanking runs.
        rom_fold = 1'b1;
        bl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) bl = ~bl;
            step(bl, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                 ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
